// File: rtl/fsm_seq_gen.sv
// ----------------------------------------------------------------------------
// fsm_seq_gen
//   Serial pattern transmitter. Shifts a PAT_W-bit pattern out MSB first, one
//   bit per clock, repeated rep_cnt times with gap_len idle cycles between
//   repeats. Every output is registered.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      start a frame (only looked at in IDLE)
//   abort      in   1      synchronous abort, beats everything else
//   pattern_in in   PAT_W  pattern, latched when start is accepted
//   rep_cnt    in   REP_W  repeat count, latched when start is accepted
//   gap_len    in   GAP_W  idle cycles between repeats, latched with start
//   data_out   out  1      registered serial data
//   busy       out  1      high from the first bit through the last bit
//   done       out  1      one-cycle pulse after the final bit
// ----------------------------------------------------------------------------
module fsm_seq_gen #(
  parameter int   PAT_W    = 4,
  parameter int   GAP_W    = 4,
  parameter int   REP_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int             BW      = $clog2(PAT_W);
  localparam logic [BW-1:0]  BIT_TOP = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   pat_r, pat_s;
  logic [REP_W-1:0]   rep_left_r, rep_left_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [BW-1:0]      bit_idx_r, bit_idx_s;
  logic [BW-1:0]      bit_dec_s;
  logic               data_s, busy_s, done_s;

  // State, latched frame parameters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pat_r      <= '0;
      rep_left_r <= '0;
      gap_r      <= '0;
      gap_cnt_r  <= '0;
      bit_idx_r  <= '0;
      data_out   <= IDLE_LVL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      pat_r      <= pat_s;
      rep_left_r <= rep_left_s;
      gap_r      <= gap_s;
      gap_cnt_r  <= gap_cnt_s;
      bit_idx_r  <= bit_idx_s;
      data_out   <= data_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they can be
  // registered without adding latency relative to the state.
  always_comb begin
    state_s    = state_r;
    pat_s      = pat_r;
    rep_left_s = rep_left_r;
    gap_s      = gap_r;
    gap_cnt_s  = gap_cnt_r;
    bit_idx_s  = bit_idx_r;
    data_s     = IDLE_LVL;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    bit_dec_s  = bit_idx_r - BW'(1);

    case (state_r)
      IDLE: begin
        if (start) begin
          if (rep_cnt != '0) begin
            pat_s      = pattern_in;
            rep_left_s = rep_cnt;
            gap_s      = gap_len;
            state_s    = SEND;
            bit_idx_s  = BIT_TOP;
            data_s     = pattern_in[PAT_W-1];
            busy_s     = 1'b1;
          end else begin
            // Empty frame: nothing is sent, but the requester still gets done.
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SEND: begin
        busy_s = 1'b1;
        if (bit_idx_r != '0) begin
          bit_idx_s = bit_dec_s;
          data_s    = pat_r[bit_dec_s];
        end else begin
          rep_left_s = rep_left_r - REP_W'(1);
          if (rep_left_r == REP_W'(1)) begin
            // Last bit of the final repeat.
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else if (gap_r == '0) begin
            state_s   = SEND;
            bit_idx_s = BIT_TOP;
            data_s    = pat_r[PAT_W-1];
          end else begin
            state_s   = GAP;
            gap_cnt_s = gap_r;
          end
        end
      end

      GAP: begin
        busy_s = 1'b1;
        if (gap_cnt_r == GAP_W'(1)) begin
          state_s   = SEND;
          bit_idx_s = BIT_TOP;
          data_s    = pat_r[PAT_W-1];
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Abort overrides start and the last-bit transition; no done pulse.
    if (abort) begin
      state_s = IDLE;
      data_s  = IDLE_LVL;
      busy_s  = 1'b0;
      done_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_fsm_seq_gen
//   Self-checking bench for fsm_seq_gen. A reference model expands each
//   accepted start into the complete list of expected (data, busy, done)
//   cycles, which is then consumed one entry per clock.
// ----------------------------------------------------------------------------
module tb_fsm_seq_gen;

  localparam int PAT_W = 4;
  localparam int GAP_W = 4;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [REP_W-1:0] rep_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             data_out, busy, done;

  fsm_seq_gen #(.PAT_W(PAT_W), .GAP_W(GAP_W), .REP_W(REP_W), .IDLE_LVL(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pattern_in (pattern_in),
    .rep_cnt    (rep_cnt),
    .gap_len    (gap_len),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected per-cycle outputs, packed as {data, busy, done}
  logic [2:0] q[$];
  logic [2:0] cur = 3'b000;

  // Build the whole frame from the rules: R copies of the pattern, G idle
  // cycles between copies, then one done cycle.
  task automatic enqueue_frame(input logic [PAT_W-1:0] p, input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) q.push_back(3'b010);
    end
    q.push_back(3'b001);
  endtask

  task automatic check(input string tag);
    total++;
    assert ({data_out, busy, done} === cur) else begin
      bad++;
      $error("FAIL %s: observed d/b/dn=%b expected=%b at %0t", tag, {data_out, busy, done}, cur, $time);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after.
  task automatic step(input logic s, input logic a, input logic [PAT_W-1:0] p,
                      input int r, input int g, input string tag);
    start = s; abort = a; pattern_in = p; rep_cnt = REP_W'(r); gap_len = GAP_W'(g);
    @(posedge clk);
    if (a) begin
      q.delete();
    end else if (s && cur[1] == 1'b0) begin
      q.delete();
      if (r == 0) q.push_back(3'b001);
      else enqueue_frame(p, r, g);
    end
    cur = (q.size() > 0) ? q.pop_front() : 3'b000;
    #1;
    check(tag);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 0, 0, tag);
  endtask

  initial begin
    // reset state
    #12;
    cur = 3'b000;
    check("reset");
    rst_n = 1'b1;
    idle_steps(2, "idle");

    // single frame 1001, rep=1, gap=0
    step(1'b1, 1'b0, 4'b1001, 1, 0, "single_start");
    idle_steps(6, "single");

    // repeats with gap: 1001 00 1001 00 1001
    step(1'b1, 1'b0, 4'b1001, 3, 2, "gap_start");
    idle_steps(18, "gap");

    // back-to-back, then start during the done cycle
    step(1'b1, 1'b0, 4'b1001, 2, 0, "b2b_start");
    idle_steps(8, "b2b");
    step(1'b1, 1'b0, 4'b0110, 1, 0, "restart_on_done");
    idle_steps(6, "restart");

    // rep=0: done only
    step(1'b1, 1'b0, 4'b1111, 0, 3, "rep0_start");
    idle_steps(3, "rep0");

    // start while busy is ignored
    step(1'b1, 1'b0, 4'b1010, 2, 1, "busy_start");
    step(1'b1, 1'b0, 4'b0101, 3, 0, "busy_ignore");
    step(1'b1, 1'b0, 4'b1111, 1, 0, "busy_ignore");
    idle_steps(10, "busy_frame");

    // abort on the 3rd bit
    step(1'b1, 1'b0, 4'b1011, 2, 0, "abort_start");
    idle_steps(2, "abort_bits");
    step(1'b0, 1'b1, 4'b0000, 0, 0, "abort_hit");
    idle_steps(4, "abort_after");

    // abort together with start in idle
    step(1'b1, 1'b1, 4'b1111, 2, 0, "abort_start_idle");
    idle_steps(3, "abort_start_idle_after");

    // abort on the final bit suppresses done
    step(1'b1, 1'b0, 4'b1100, 1, 0, "abort_last_start");
    idle_steps(3, "abort_last_bits");
    step(1'b0, 1'b1, 4'b0000, 0, 0, "abort_last");
    idle_steps(2, "abort_last_after");

    // reset mid-frame: immediate, no done
    step(1'b1, 1'b0, 4'b1111, 3, 1, "rst_start");
    idle_steps(3, "rst_bits");
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    cur = 3'b000;
    check("rst_midframe");
    #1 rst_n = 1'b1;
    idle_steps(3, "rst_after");

    // counters at their maximum values run to completion
    step(1'b1, 1'b0, 4'b1101, 255, 15, "max_start");
    idle_steps(255 * 4 + 254 * 15 + 3, "max_frame");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(59) == 0) ? 1'b1 : 1'b0,
           PAT_W'($urandom), int'($urandom_range(4)), int'($urandom_range(3)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
